// File: rtl/imem_responder.sv
// Single-outstanding instruction-fetch responder: rsp_valid rises LATENCY+1 cycles after accept.
// Response holds while rsp_ready=0 (no new accepts); flush wins over accept; IMEM_STATS_EN adds counters.
module imem_responder #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0]           stat_req_cnt,
  output logic [15:0]           stat_err_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [2:0] LAT = 3'(LATENCY);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  logic                  accept;
  logic                  load_rsp;
  logic [31:0]           rd_addr;
  logic                  rd_err;
  logic [ADDR_WIDTH-1:0] rd_idx;

  assign req_ready = !flush && (state_q == S_IDLE || (state_q == S_RESP && rsp_ready));
  assign accept    = req_valid && req_ready;

  assign rd_err = (rd_addr[1:0] != 2'b00) || ((rd_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign rd_idx = rd_addr[ADDR_WIDTH+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    load_rsp = 1'b0;
    rd_addr  = addr_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          if (cnt_q <= 3'd1) begin
            state_d  = S_RESP;
            cnt_d    = 3'd0;
            load_rsp = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        S_RESP: if (rsp_ready && !accept) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      // A new accept (from IDLE or on the RESP handshake) overrides the above.
      if (accept) begin
        addr_d = req_addr;
        cnt_d  = LAT;
        if (LAT == 3'd0) begin
          state_d  = S_RESP;
          load_rsp = 1'b1;
          rd_addr  = req_addr;
        end else begin
          state_d = S_WAIT;
        end
      end
    end
  end

  // Preload port; the response read below sees the pre-write word on a same-edge collision.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= (state_d == S_RESP);
      if (load_rsp) begin
        rsp_err_q  <= rd_err;
        rsp_data_q <= rd_err ? NOP_WORD : mem_q[rd_idx];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

`ifdef IMEM_STATS_EN
  logic [31:0] stat_req_q;
  logic [15:0] stat_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_req_q <= 32'd0;
      stat_err_q <= 16'd0;
    end else begin
      if (accept && stat_req_q != 32'hFFFF_FFFF) stat_req_q <= stat_req_q + 32'd1;
      if (rsp_valid_q && rsp_ready && rsp_err_q && stat_err_q != 16'hFFFF)
        stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign stat_req_cnt = stat_req_q;
  assign stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: three instances (LATENCY 0/1/3) share stimulus, one observed per test.
// Expected words/timing come from a byte-address memory model; IMEM_STATS_EN also checks the counters.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush, rsp_ready, wr_en;
  logic [31:0] req_addr;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  logic [2:0]  rdy_w, vld_w, err_w;
  logic [31:0] dat_w [3];
`ifdef IMEM_STATS_EN
  logic [31:0] sreq_w [3];
  logic [15:0] serr_w [3];
`endif

  logic [31:0] mem_m [1024];
  logic [31:0] pend_q [$];
  int          lat_of [3] = '{0, 1, 3};
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[0]), .req_addr(req_addr),
    .flush(flush), .rsp_valid(vld_w[0]), .rsp_ready(rsp_ready), .rsp_data(dat_w[0]),
    .rsp_err(err_w[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef IMEM_STATS_EN
    , .stat_req_cnt(sreq_w[0]), .stat_err_cnt(serr_w[0])
`endif
  );

  imem_responder #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[1]), .req_addr(req_addr),
    .flush(flush), .rsp_valid(vld_w[1]), .rsp_ready(rsp_ready), .rsp_data(dat_w[1]),
    .rsp_err(err_w[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef IMEM_STATS_EN
    , .stat_req_cnt(sreq_w[1]), .stat_err_cnt(serr_w[1])
`endif
  );

  imem_responder #(.LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[2]), .req_addr(req_addr),
    .flush(flush), .rsp_valid(vld_w[2]), .rsp_ready(rsp_ready), .rsp_data(dat_w[2]),
    .rsp_err(err_w[2]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef IMEM_STATS_EN
    , .stat_req_cnt(sreq_w[2]), .stat_err_cnt(serr_w[2])
`endif
  );

  function automatic logic exp_err(input logic [31:0] a);
    return (a % 32'd4 != 32'd0) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return exp_err(a) ? NOP : mem_m[a[11:2]];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; wr_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic preload;
    logic [31:0] plan [4];
    plan = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h00000013};
    for (int i = 0; i < 64; i++) begin
      wr_en   = 1'b1;
      wr_addr = 10'(i);
      wr_data = (i < 4) ? plan[i] : $urandom;
      mem_m[i] = wr_data;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0; wr_en = 1'b0;
    req_addr = 32'd0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    for (int s = 0; s < 3; s++) begin
      total++; if (rdy_w[s] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d] got %b want 1", s, rdy_w[s]); end
      total++; if (vld_w[s] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d] got %b want 0", s, vld_w[s]); end
      total++; if (dat_w[s] !== 32'd0) begin bad++; $display("FAIL reset_data[%0d] got %h want 0", s, dat_w[s]); end
      total++; if (err_w[s] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got %b want 0", s, err_w[s]); end
    end
    rst = 1'b0;
  endtask

  // Streams pend_q through instance s, checking latency, data, error, stability and req_ready each cycle.
  task automatic test_stream(input int s, input bit rnd_rdy, input bit rnd_vld, input string name);
    logic [31:0] exp_a [$];
    int          exp_c [$];
    bit          shown, v, exp_ready;
    int          budget;
    do_reset();
    shown = 1'b0; budget = 0;
    while ((pend_q.size() > 0 || exp_a.size() > 0) && budget < 2000) begin
      v = vld_w[s];
      if (v) begin
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL %s spurious rsp_valid at cycle %0d", name, cyc);
        end else begin
          if (!shown) begin
            total++;
            if (cyc !== exp_c[0]) begin bad++; $display("FAIL %s latency got cycle %0d want %0d", name, cyc, exp_c[0]); end
            shown = 1'b1;
          end
          total++;
          if (dat_w[s] !== exp_word(exp_a[0])) begin
            bad++; $display("FAIL %s data addr=%h got %h want %h", name, exp_a[0], dat_w[s], exp_word(exp_a[0]));
          end
          total++;
          if (err_w[s] !== exp_err(exp_a[0])) begin
            bad++; $display("FAIL %s err addr=%h got %b want %b", name, exp_a[0], err_w[s], exp_err(exp_a[0]));
          end
        end
      end
      rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      req_valid = (pend_q.size() > 0) && (rnd_vld ? ($urandom_range(0, 3) != 0) : 1'b1);
      req_addr  = req_valid ? pend_q[0] : $urandom;
      #1;
      exp_ready = (exp_a.size() == 0) || (v && rsp_ready);
      total++;
      if (rdy_w[s] !== exp_ready) begin bad++; $display("FAIL %s req_ready cycle %0d got %b want %b", name, cyc, rdy_w[s], exp_ready); end
      if (v && rsp_ready && exp_a.size() > 0) begin
        void'(exp_a.pop_front()); void'(exp_c.pop_front()); shown = 1'b0;
      end
      if (req_valid && rdy_w[s]) begin
        exp_a.push_back(pend_q.pop_front());
        exp_c.push_back(cyc + lat_of[s] + 1);
      end
      tick();
      budget++;
    end
    if (budget >= 2000) begin
      total++; bad++;
      $display("FAIL %s timeout pending=%0d outstanding=%0d want 0 0", name, pend_q.size(), exp_a.size());
      pend_q.delete();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 7))
          0: a = $urandom;
          1: a = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
          default: a = 32'($urandom_range(0, 63)) * 32'd4;
        endcase
        pend_q.push_back(a);
      end
      test_stream(s, 1'b1, 1'b1, "random");
    end
  endtask

  task automatic test_flush;
    int seen, nv;
    logic [31:0] d;
    logic e;
    do_reset();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    #1;
    total++; if (rdy_w[2] !== 1'b1) begin bad++; $display("FAIL flush_first_accept got %b want 1", rdy_w[2]); end
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
    #1;
    total++; if (rdy_w[2] !== 1'b0) begin bad++; $display("FAIL flush_ready got %b want 0", rdy_w[2]); end
    tick();
    flush = 1'b0;
    total++; if (vld_w[2] !== 1'b0) begin bad++; $display("FAIL flush_valid got %b want 0", vld_w[2]); end
    #1;
    total++; if (rdy_w[2] !== 1'b1) begin bad++; $display("FAIL flush_next_ready got %b want 1", rdy_w[2]); end
    tick();
    req_valid = 1'b0;
    seen = -1; nv = 0; d = '0; e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (vld_w[2]) begin
        nv++;
        if (seen < 0) begin seen = i; d = dat_w[2]; e = err_w[2]; end
      end
      tick();
    end
    total++; if (seen !== lat_of[2]) begin bad++; $display("FAIL flush_resp_time got %0d want %0d", seen, lat_of[2]); end
    total++; if (nv !== 1) begin bad++; $display("FAIL flush_resp_count got %0d want 1", nv); end
    total++; if (d !== exp_word(32'h8)) begin bad++; $display("FAIL flush_resp_data got %h want %h", d, exp_word(32'h8)); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL flush_resp_err got %b want 0", e); end
  endtask

  task automatic test_stall_rbw;
    logic [31:0] old_w, new_w;
    do_reset();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    #1;
    total++; if (rdy_w[1] !== 1'b1) begin bad++; $display("FAIL stall_accept got %b want 1", rdy_w[1]); end
    tick();
    req_addr = 32'h4;
    old_w = mem_m[0]; new_w = ~old_w;
    wr_en = 1'b1; wr_addr = 10'd0; wr_data = new_w;
    tick();
    wr_en = 1'b0; mem_m[0] = new_w;
    for (int i = 0; i < 5; i++) begin
      total++; if (vld_w[1] !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got %b want 1", i, vld_w[1]); end
      total++; if (dat_w[1] !== old_w) begin bad++; $display("FAIL stall_data[%0d] got %h want %h", i, dat_w[1], old_w); end
      total++; if (err_w[1] !== 1'b0) begin bad++; $display("FAIL stall_err[%0d] got %b want 0", i, err_w[1]); end
      total++; if (rdy_w[1] !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got %b want 0", i, rdy_w[1]); end
      tick();
    end
    flush = 1'b1; req_valid = 1'b0;
    tick();
    flush = 1'b0;
    total++; if (vld_w[1] !== 1'b0) begin bad++; $display("FAIL resp_flush_valid got %b want 0", vld_w[1]); end
    total++; if (dat_w[1] !== old_w) begin bad++; $display("FAIL resp_flush_data got %h want %h", dat_w[1], old_w); end
    total++; if (err_w[1] !== 1'b0) begin bad++; $display("FAIL resp_flush_err got %b want 0", err_w[1]); end
    pend_q = '{32'h0};
    test_stream(1, 1'b0, 1'b0, "after_write");
  endtask

  task automatic test_reset_mid;
    int nv;
    do_reset();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 10'd5; wr_data = ~mem_m[5];
    tick();
    rst = 1'b0; wr_en = 1'b0;
    total++; if (vld_w[2] !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", vld_w[2]); end
    #1;
    total++; if (rdy_w[2] !== 1'b1) begin bad++; $display("FAIL midrst_ready got %b want 1", rdy_w[2]); end
`ifdef IMEM_STATS_EN
    total++; if (sreq_w[2] !== 32'd0) begin bad++; $display("FAIL stat_req_clear got %0d want 0", sreq_w[2]); end
    total++; if (serr_w[2] !== 16'd0) begin bad++; $display("FAIL stat_err_clear got %0d want 0", serr_w[2]); end
`endif
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (vld_w[2]) nv++;
      tick();
    end
    total++; if (nv !== 0) begin bad++; $display("FAIL midrst_lost got %0d responses want 0", nv); end
    pend_q = '{32'h0, 32'h4, 32'h2, 32'h14};
    test_stream(0, 1'b0, 1'b0, "post_reset");
`ifdef IMEM_STATS_EN
    total++; if (sreq_w[0] !== 32'd4) begin bad++; $display("FAIL stat_req_cnt got %0d want 4", sreq_w[0]); end
    total++; if (serr_w[0] !== 16'd1) begin bad++; $display("FAIL stat_err_cnt got %0d want 1", serr_w[0]); end
`endif
  endtask

  initial begin
    test_reset();
    preload();
    pend_q = '{32'h0, 32'h4, 32'h8};
    test_stream(1, 1'b0, 1'b0, "fetch_lat1");
    pend_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    test_stream(0, 1'b0, 1'b0, "back_to_back");
    pend_q = '{32'h2, 32'h1000};
    test_stream(1, 1'b0, 1'b0, "err_fetch");
    test_flush();
    test_reset_mid();
    test_random();
    test_stall_rbw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
